// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the serial subtractor: FSM encodings and
// the bit-counter width helper.
package serial_subtractor_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle of the serial subtractor; master drives operands,
// slave returns status and result.
interface serial_subtractor_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, zero, ovf);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, zero, ovf);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor cell: diff = a - b - bin, bout set on underflow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one reused full-subtractor cell, LSB first,
// borrow carried in a flop between cycles.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_w(N);

  logic [1:0]    state;
  logic [N-1:0]  a_sh, b_sh, res_sh;
  logic          a_msb, b_msb;
  logic          br;
  logic [CW-1:0] cnt;
  logic          d, br_nxt;
  logic [N-1:0]  res_nxt;

  logic          busy_r, done_r, bout_r, zero_r, ovf_r;
  logic [N-1:0]  diff_r;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d),
    .bout (br_nxt)
  );

  // Result fills from the MSB end so the LSB lands in bit 0 after N shifts.
  assign res_nxt = {d, res_sh[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      br     <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            a_msb  <= bus.a[N-1];
            b_msb  <= bus.b[N-1];
            br     <= bus.bin;
            res_sh <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          br     <= br_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            diff_r <= res_nxt;
            bout_r <= br_nxt;
            zero_r <= (res_nxt == '0);
            ovf_r  <= (a_msb != b_msb) && (res_nxt[N-1] != a_msb);
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end
        end
        // start is deliberately not looked at here; the next IDLE cycle takes it.
        ST_DONE: begin
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.zero = zero_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an integer
// arithmetic reference model.
module tb_serial_subtractor;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] exp_prev = '0;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: unsigned integer subtraction; ovf from the sign-bit rule.
  function automatic logic [N+2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic bin);
    int full;
    logic [N-1:0] d;
    logic bo, z, ov;
    full = int'(a) - int'(b) - int'(bin);
    d  = N'(full);
    bo = (full < 0);
    z  = (d == '0);
    ov = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
    return {ov, z, bo, d};
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                        input bit scramble, input string name);
    logic [N+2:0] exp;
    int lat = -1;
    int busy_n = 0;
    int held_bad = 0;
    exp = model(a, b, bin);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (scramble) begin
        bus.a = N'($urandom); bus.b = N'($urandom); bus.bin = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = i - 1;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.diff !== exp_prev) held_bad++;
    end
    bus.start = 1'b0;
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, N);
    end
    checks++;
    if (busy_n != N) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, N);
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL %s diff_held: %0d cycles differed from %h", name, held_bad, exp_prev);
    end
    checks++;
    if ({bus.ovf, bus.zero, bus.bout, bus.diff} !== exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: got diff=%h bout=%b zero=%b ovf=%b busy=%b want diff=%h bout=%b zero=%b ovf=%b busy=0",
               name, bus.diff, bus.bout, bus.zero, bus.ovf, bus.busy,
               exp[N-1:0], exp[N], exp[N+1], exp[N+2]);
    end
    exp_prev = exp[N-1:0];
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b one cycle after pulse, want 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    rst = 1'b0;
    exp_prev = '0;
  endtask

  task automatic test_directed();
    run_op(8'd100, 8'd37, 1'b0, 1'b0, "d_100_37");
    run_op(8'd5,   8'd9,  1'b0, 1'b0, "d_5_9");
    run_op(8'h80,  8'h01, 1'b0, 1'b0, "d_ovf_neg");
    run_op(8'h7F,  8'hFF, 1'b0, 1'b0, "d_ovf_pos");
    run_op(8'h2A,  8'h2A, 1'b0, 1'b0, "d_zero");
    run_op(8'h2A,  8'h2A, 1'b1, 1'b0, "d_zero_bin");
  endtask

  task automatic test_ignore_inputs();
    run_op(8'd100, 8'd37, 1'b0, 1'b1, "ignore_busy_inputs");
  endtask

  task automatic test_reset_abort();
    int done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = N'($urandom); bus.b = N'($urandom); bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_prev = '0;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%b done=%b diff=%h want busy=0 done=0 diff=00",
               bus.busy, bus.done, bus.diff);
    end
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d cycles with done/busy after reset, want 0", done_seen);
    end
    run_op(8'd3, 8'd1, 1'b0, 1'b0, "after_abort");
  endtask

  // With start held, each op spans IDLE + N BUSY + DONE, so pulses repeat every N+2.
  task automatic test_back_to_back();
    logic [N-1:0] ca, cb;
    logic         cbin;
    logic [N+2:0] exp;
    int gap, held_bad;
    ca = N'($urandom); cb = N'($urandom); cbin = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ca; bus.b = cb; bus.bin = cbin;
    for (int k = 0; k < 4; k++) begin
      exp = model(ca, cb, cbin);
      gap = -1;
      held_bad = 0;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (bus.done === 1'b1) begin
          gap = i;
          break;
        end
        if (bus.busy === 1'b1 && bus.diff !== exp_prev) held_bad++;
      end
      checks++;
      if (gap != ((k == 0) ? N + 1 : N + 2)) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: got %0d want %0d", k, gap, (k == 0) ? N + 1 : N + 2);
      end
      checks++;
      if ({bus.ovf, bus.zero, bus.bout, bus.diff} !== exp || held_bad != 0) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got diff=%h bout=%b zero=%b ovf=%b held_bad=%0d want diff=%h bout=%b zero=%b ovf=%b",
                 k, bus.diff, bus.bout, bus.zero, bus.ovf, held_bad,
                 exp[N-1:0], exp[N], exp[N+1], exp[N+2]);
      end
      exp_prev = exp[N-1:0];
      ca = N'($urandom); cb = N'($urandom); cbin = 1'($urandom);
      bus.a = ca; bus.b = cb; bus.bin = cbin;
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    test_reset();
    test_directed();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
